// File: rtl/feeder_pkg.sv
// feeder_pkg: shared types for the dispenser control FSM.
// State encoding doubles as the actuator/status code.
package feeder_pkg;

  localparam int CONT_W = 16;

  typedef enum logic [1:0] {
    OFF      = 2'b00,
    WAIT     = 2'b01,
    READY    = 2'b10,
    DISPENSE = 2'b11
  } state_t;

endpackage

// File: rtl/feeder_moore_fsm_if.sv
// feeder_moore_fsm_if: sensor/timer inputs and status code.
// master drives the inputs, slave is the FSM.
interface feeder_moore_fsm_if;
  import feeder_pkg::*;

  logic              modo;
  logic              sensor;
  logic [CONT_W-1:0] cont;
  logic [1:0]        outs;

  modport master (
    output modo,
    output sensor,
    output cont,
    input  outs
  );

  modport slave (
    input  modo,
    input  sensor,
    input  cont,
    output outs
  );

endinterface

// File: rtl/feeder_moore_fsm.sv
// feeder_moore_fsm: Moore FSM for the pet-food dispenser.
// outs is the state register itself, so no comb input->output path.
module feeder_moore_fsm
  import feeder_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  feeder_moore_fsm_if.slave bus
);

  state_t state;
  state_t next;

  logic cont_live;
  assign cont_live = |bus.cont;

  // next-state: modo=0 forces OFF ahead of any state rule
  always_comb begin
    next = state;
    if (!bus.modo) begin
      next = OFF;
    end else begin
      case (state)
        OFF:      next = WAIT;
        WAIT:     if (bus.sensor) next = READY;
        READY: begin
          if (cont_live)        next = DISPENSE;
          else if (!bus.sensor) next = WAIT;
        end
        DISPENSE: if (!cont_live) next = WAIT;
        default:  next = OFF;
      endcase
    end
  end

  // state register with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) state <= OFF;
    else       state <= next;
  end

  assign bus.outs = state;

endmodule

// File: tb/tb_feeder_moore_fsm.sv
// tb_feeder_moore_fsm: directed vectors with a scoreboard queue.
// Stimulus pushes expected outs; monitor pops after each edge.
module tb_feeder_moore_fsm;

  logic clk;
  logic reset;

  feeder_moore_fsm_if bus ();

  feeder_moore_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        m;
    logic        s;
    logic [15:0] c;
    logic [1:0]  e;
    string       tag;
  } vec_t;

  logic [1:0] expq [$];
  string      tagq [$];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic drive(input vec_t v);
    @(negedge clk);
    reset      = v.r;
    bus.modo   = v.m;
    bus.sensor = v.s;
    bus.cont   = v.c;
    expq.push_back(v.e);
    tagq.push_back(v.tag);
  endtask

  task automatic rep(input vec_t v, input int n);
    for (int i = 0; i < n; i++) drive(v);
  endtask

  // monitor: outs is valid #1 after every rising edge
  initial begin
    logic [1:0] e;
    string      t;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        t = tagq.pop_front();
        n_cmp++;
        if (bus.outs !== e) begin
          n_bad++;
          $display("FAIL %s: outs=%b expected=%b at %0t",
                   t, bus.outs, e, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b0;
    bus.modo   = 1'b0;
    bus.sensor = 1'b0;
    bus.cont   = '0;
    @(negedge clk);

    drive('{1, 0, 0, 16'd0, 2'b00, "reset"});
    rep('{0, 0, 0, 16'd0, 2'b00, "idle_modo0"}, 3);

    drive('{0, 1, 0, 16'd0, 2'b01, "enable"});
    rep('{0, 1, 0, 16'd0, 2'b01, "wait_hold"}, 10);

    drive('{0, 1, 1, 16'd0, 2'b10, "bowl_empty"});
    rep('{0, 1, 1, 16'd0, 2'b10, "ready_hold"}, 10);

    drive('{0, 1, 1, 16'd1, 2'b11, "dispense"});
    rep('{0, 1, 1, 16'd1, 2'b11, "disp_hold"}, 5);
    rep('{0, 1, 0, 16'd1, 2'b11, "disp_sens_ign"}, 5);
    drive('{0, 1, 1, 16'd0, 2'b01, "disp_done"});
    drive('{0, 1, 1, 16'd0, 2'b10, "re_ready"});

    drive('{0, 1, 1, 16'hFFFF, 2'b11, "disp_ffff"});
    drive('{0, 0, 1, 16'hFFFF, 2'b00, "abort_modo"});

    drive('{0, 1, 1, 16'hFFFF, 2'b01, "re_enable"});
    drive('{0, 1, 1, 16'hFFFF, 2'b10, "re_ready2"});
    drive('{0, 1, 1, 16'hFFFF, 2'b11, "re_disp"});
    drive('{1, 1, 1, 16'hFFFF, 2'b00, "abort_reset"});
    drive('{1, 1, 1, 16'hFFFF, 2'b00, "reset_hold"});
    drive('{0, 1, 1, 16'hFFFF, 2'b01, "post_reset"});
    drive('{0, 1, 1, 16'd0, 2'b10, "ready3"});
    drive('{0, 1, 1, 16'd0, 2'b10, "ready3_hold"});
    drive('{0, 1, 0, 16'd0, 2'b01, "refill"});

    drive('{0, 0, 1, 16'd0, 2'b00, "to_off"});
    drive('{0, 1, 1, 16'd0, 2'b01, "off_to_wait"});
    drive('{0, 1, 1, 16'd0, 2'b10, "wait_to_ready"});

    drive('{0, 1, 0, 16'd5, 2'b11, "cont_over_sens"});
    drive('{0, 0, 0, 16'd0, 2'b00, "modo0_in_disp"});
    drive('{0, 0, 1, 16'd7, 2'b00, "modo0_wins"});

    repeat (3) @(posedge clk);
    #2;
    if (expq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: left=%0d expected=0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
